rr_mux_param: RTL and testbench

RR_MUX_PARAM -- requirements
Module: rr_mux_param

---
 rtl/rr_mux_param_pkg.sv | 21 ++
 rtl/rr_mux_param_arbiter.sv | 48 ++++
 rtl/rr_mux_param.sv | 195 +++++++++++++++++++
 tb/tb_rr_mux_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_param_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_pkg
// Shared types and constants for the round-robin / external-select output mux.
//   state_t      : output register occupancy (EMPTY, FULL)
//   MODE_EXT     : mode value selecting the channel given by sel_ext
//   MODE_RR      : mode value selecting channels round-robin from ptr
//   XFER_CNT_MAX : saturation value of the optional transfer counter
// -----------------------------------------------------------------------------
package rr_mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic MODE_EXT = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam logic [15:0] XFER_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_mux_param_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter_param
// Purely combinational rotating-priority arbiter. Searches req upward starting
// at index ptr, wrapping from M-1 back to 0, and grants the first set bit.
// Holds no state; the pointer is owned and advanced by the parent.
//
// Ports:
//   req   [M-1:0]   in   request vector
//   ptr   [SW-1:0]  in   index with highest priority this cycle (0..M-1)
//   en    1         in   when 0 nothing is granted
//   grant [M-1:0]   out  one-hot grant (all 0 when nothing granted)
//   g     [SW-1:0]  out  index of the granted request (0 when none)
//   any   1         out  a request was granted
// -----------------------------------------------------------------------------
module rr_arbiter_param #(
    parameter int M = 4
) (
    input  logic [M-1:0]         req,
    input  logic [$clog2(M)-1:0] ptr,
    input  logic                 en,
    output logic [M-1:0]         grant,
    output logic [$clog2(M)-1:0] g,
    output logic                 any
);

    localparam int SW = $clog2(M);

    always_comb begin
        logic [SW-1:0] idx;
        idx   = '0;
        grant = '0;
        g     = '0;
        any   = 1'b0;
        if (en) begin
            for (int k = 0; k < M; k++) begin
                // Wrap explicitly on M rather than 2**SW so non-power-of-two
                // channel counts never visit unused indices.
                idx = SW'((int'(ptr) + k) % M);
                if (!any && req[idx]) begin
                    any        = 1'b1;
                    grant[idx] = 1'b1;
                    g          = idx;
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux_param.sv
// -----------------------------------------------------------------------------
// rr_mux_param
// M-channel, N-bit valid/ready multiplexer with a single registered output
// slot. Channel choice is either external (sel_ext) or round-robin from an
// internal pointer. The output register can be drained and reloaded in the
// same cycle, so a continuous stream runs at one word per clock.
//
// Optional feature: define RR_MUX_PARAM_XFER_CNT_EN to build a saturating
// 16-bit count of output transfers on out_xfer_cnt; when undefined the counter
// is not built and out_xfer_cnt is tied to 0.
//
// Ports:
//   clk           1       in   clock, rising edge
//   rst           1       in   synchronous active-high reset
//   in_data       M*N     in   channel i at bits [i*N +: N]
//   in_valid      M       in   per-channel request
//   in_ready      M       out  per-channel accept, at most one bit set
//   mode          1       in   MODE_EXT (0) / MODE_RR (1)
//   sel_ext       SW      in   channel used in MODE_EXT (>= M selects none)
//   out_data      N       out  registered selected word
//   out_valid     1       out  output register holds a word
//   out_ready     1       in   downstream accept
//   out_sel       SW      out  channel index of out_data
//   out_xfer_cnt  16      out  output transfer count (0 unless enabled)
//
// State table:
//   state | meaning
//   EMPTY | output register holds no word; out_valid = 0
//   FULL  | output register holds a word;  out_valid = 1
// -----------------------------------------------------------------------------
module rr_mux_param
    import rr_mux_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M*N-1:0]       in_data,
    input  logic [M-1:0]         in_valid,
    output logic [M-1:0]         in_ready,
    input  logic                 mode,
    input  logic [$clog2(M)-1:0] sel_ext,
    output logic [N-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(M)-1:0] out_sel,
    output logic [15:0]          out_xfer_cnt
);

    localparam int SW = $clog2(M);

    state_t        state_q, state_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load_en;
    logic          rr_en;
    logic [M-1:0]  rr_grant;
    logic [SW-1:0] rr_g;
    logic          rr_any;
    logic [M-1:0]  ext_grant;
    logic [M-1:0]  grant;
    logic [SW-1:0] g;
    logic          xfer;
    logic [N-1:0]  g_data;

    // The slot can take a new word when empty, or when the current word
    // leaves this same cycle.
    assign load_en = (state_q == EMPTY) | out_ready;

    // Reset gates the grant so in_ready stays low during reset.
    assign rr_en = load_en & ~rst & (mode == MODE_RR);

    rr_arbiter_param #(
        .M (M)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .en    (rr_en),
        .grant (rr_grant),
        .g     (rr_g),
        .any   (rr_any)
    );

    // External select: compare against each legal index so an out-of-range
    // sel_ext simply matches nothing.
    always_comb begin
        ext_grant = '0;
        if (load_en && !rst && (mode == MODE_EXT)) begin
            for (int i = 0; i < M; i++) begin
                if (sel_ext == SW'(i)) begin
                    ext_grant[i] = in_valid[i];
                end
            end
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant = rr_grant;
            g     = rr_g;
            xfer  = rr_any;
        end else begin
            grant = ext_grant;
            g     = sel_ext;
            xfer  = |ext_grant;
        end
    end

    assign in_ready = grant;

    always_comb begin
        g_data = '0;
        for (int i = 0; i < M; i++) begin
            if (g == SW'(i)) begin
                g_data = in_data[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        ptr_d      = ptr_q;

        case (state_q)
            EMPTY: begin
                if (xfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (xfer) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (xfer) begin
            out_data_d = g_data;
            out_sel_d  = g;
            if (mode == MODE_RR) begin
                ptr_d = (int'(g) == M - 1) ? '0 : g + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_sel_q  <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

`ifdef RR_MUX_PARAM_XFER_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (out_valid && out_ready && (xfer_cnt_q != XFER_CNT_MAX)) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign out_xfer_cnt = xfer_cnt_q;
`else
    assign out_xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_mux_param.sv
module tb_rr_mux_param;

    localparam int N = 8;
    localparam int M = 4;

`ifdef RR_MUX_PARAM_XFER_CNT_EN
    localparam int          LONG_RUN = 32'h10005;
    localparam logic [15:0] CNT_EXP  = 16'hFFFF;
`else
    localparam int          LONG_RUN = 3;
    localparam logic [15:0] CNT_EXP  = 16'h0000;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [M*N-1:0] in_data;
    logic [M-1:0]   in_valid;
    logic [M-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel_ext;
    logic [N-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_sel;
    logic [15:0]    out_xfer_cnt;

    int total = 0;
    int bad   = 0;

    // expected word: {sel[1:0], data[7:0]}
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    rr_mux_param #(.N(N), .M(M)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mode         (mode),
        .sel_ext      (sel_ext),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sel      (out_sel),
        .out_xfer_cnt (out_xfer_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic [7:0] data);
        exp_q.push_back({sel, data});
    endtask

    // Scoreboard monitor: every accepted output word is popped and compared.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got sel=%0d data=%0h expected no word", out_sel, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sel", 32'(out_sel), 32'(e[9:8]));
                    chk("sb_data", 32'(out_data), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_seq[5];
        rr_seq = '{0, 1, 2, 3, 0};

        // Reset with every channel requesting
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 32'h04030201;
        mode      = 1'b1;
        sel_ext   = 2'd0;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_data", 32'(out_data), 32'h0);
            chk("rst_out_sel", 32'(out_sel), 32'h0);
            chk("rst_xfer_cnt", 32'(out_xfer_cnt), 32'h0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 4'b0000;

        // Round-robin stream, one word per cycle
        in_data  = 32'hA3A2A1A0;
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_stream_ready", 32'(in_ready), 32'(1 << rr_seq[k]));
            push(2'(rr_seq[k]), 8'(8'hA0 + rr_seq[k]));
            tick();
        end
        in_valid = 4'b0000;
        tick();

        // Move ptr to 2, then check wrap-around to channel 0
        in_data  = 32'h00002100;
        in_data[15:8] = 8'h11;
        in_valid = 4'b0010;
        @(negedge clk);
        chk("rr_ptr_to_2", 32'(in_ready), 32'b0010);
        push(2'd1, 8'h11);
        tick();
        in_data  = 32'h00002120;
        in_valid = 4'b0011;
        @(negedge clk);
        chk("rr_wrap", 32'(in_ready), 32'b0001);
        push(2'd0, 8'h20);
        tick();
        @(negedge clk);
        chk("rr_ptr_after_wrap", 32'(in_ready), 32'b0010);
        push(2'd1, 8'h21);
        tick();
        in_valid = 4'b0000;
        tick();

        // External select on a channel that is not requesting
        mode     = 1'b0;
        sel_ext  = 2'd1;
        in_valid = 4'b1101;
        @(negedge clk);
        chk("ext_not_valid", 32'(in_ready), 32'h0);
        tick();

        // External select with back-pressure: word held stable
        sel_ext   = 2'd2;
        in_valid  = 4'b0100;
        in_data   = 32'h005C0000;
        out_ready = 1'b0;
        @(negedge clk);
        chk("ext_load_ready", 32'(in_ready), 32'b0100);
        push(2'd2, 8'h5C);
        tick();
        in_data = 32'h00990000;
        repeat (3) begin
            @(negedge clk);
            chk("hold_ready", 32'(in_ready), 32'h0);
            chk("hold_valid", 32'(out_valid), 32'h1);
            chk("hold_data", 32'(out_data), 32'h5C);
            chk("hold_sel", 32'(out_sel), 32'h2);
            tick();
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        tick();

        // Simultaneous drain and load (ptr is 2: search 2,3,0 -> 0)
        mode      = 1'b1;
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        in_data   = 32'h00000030;
        @(negedge clk);
        chk("pre_load_ready", 32'(in_ready), 32'b0001);
        push(2'd0, 8'h30);
        tick();
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        in_data   = 32'h77000000;
        @(negedge clk);
        chk("drain_load_ready", 32'(in_ready), 32'b1000);
        push(2'd3, 8'h77);
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("no_bubble_valid", 32'(out_valid), 32'h1);
        chk("no_bubble_data", 32'(out_data), 32'h77);
        tick();
        @(negedge clk);
        chk("drained_valid", 32'(out_valid), 32'h0);

        // Reset discards a held word
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        in_data   = 32'h00000042;
        tick();
        rst      = 1'b1;
        in_valid = 4'b1111;
        @(negedge clk);
        chk("rst_mid_ready", 32'(in_ready), 32'h0);
        tick();
        rst      = 1'b0;
        in_valid = 4'b0000;
        @(negedge clk);
        chk("rst_discard_valid", 32'(out_valid), 32'h0);
        chk("rst_discard_data", 32'(out_data), 32'h0);
        tick();

        // Transfer counter run (saturates when the counter is built)
        mode      = 1'b0;
        sel_ext   = 2'd1;
        in_valid  = 4'b0010;
        in_data   = 32'h00005A00;
        out_ready = 1'b1;
        for (int i = 0; i < LONG_RUN; i++) begin
            push(2'd1, 8'h5A);
            tick();
        end
        in_valid = 4'b0000;
        tick();
        @(negedge clk);
        chk("xfer_cnt", 32'(out_xfer_cnt), 32'(CNT_EXP));
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
